job_dispatch_arbiter: RTL and testbench
=======================================

# job_dispatch_arbiter

Shares one AXI-Lite job adaptor (the `engine_start`/`payload`/`engine_done`/`return_code` front end of an HLS action) between `NUM_REQ` job requesters. Arbitration is round-robin. For each granted job the block:
- latches the payload and launches the engine;
- waits for completion or a timeout;
- returns the return code to the granted requester through a ready/valid response.

It sits between the job manager's per-context queues and the adaptor.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `PAYLOAD_WIDTH`, 1024, job payload width
- `RC_WIDTH`, 32, return code width
- `TIMEOUT_CYCLES`, 1048575, WAIT-state cycle limit; 0 disables the timeout
- `TO_WIDTH`, 20, timeout counter width; `TIMEOUT_CYCLES` < 2^`TO_WIDTH`

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock
- `resetn`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester job request (level)
- `req_payload`  in  NUM_REQ*PAYLOAD_WIDTH  payload; slice i belongs to requester i
- `req_ready`  out  NUM_REQ  one-hot, one-cycle acceptance pulse
- `rsp_valid`  out  NUM_REQ  one-hot, held until the matching `rsp_ready`
- `rsp_ready`  in  NUM_REQ  response accept
- `rsp_code`  out  RC_WIDTH  return code of the job being answered
- `rsp_timeout`  out  1  job ended by timeout
- `busy`  out  1  FSM not in IDLE
- `grant_id`  out  3  index of the current or last granted requester
- `engine_start`  out  1  one-cycle start pulse to the adaptor
- `engine_payload`  out  PAYLOAD_WIDTH  registered payload, stable from START to the next grant
- `engine_done`  in  1  adaptor done; a level, possibly stale-high at start
- `engine_return_code`  in  RC_WIDTH  adaptor return code, valid while `engine_done`=1

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is set, choose the first set bit scanning upward from `(last_grant+1) mod NUM_REQ`, with wrap.
  - Assert `req_ready[i]` combinationally in that cycle.
  - Register `engine_payload <= slice i`, `grant_id <= i`, `last_grant <= i`, then go to START.
  - With no `req_valid`, stay in IDLE.
- **START**
  - `engine_start`=1 for exactly one cycle. `engine_done` is ignored, since it may still be high from the previous job.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - Sample `engine_done` every cycle.
  - If `engine_done`=1: register `rsp_code <= engine_return_code`, `rsp_timeout <= 0`, go to RESP.
  - Otherwise, if `TIMEOUT_CYCLES`≠0 and counter == `TIMEOUT_CYCLES`-1: `rsp_code <= 0`, `rsp_timeout <= 1`, go to RESP.
  - Otherwise increment the counter.
  - If done and timeout occur in the same cycle, done wins.
- **RESP**
  - `rsp_valid[grant_id]`=1. `rsp_code` and `rsp_timeout` are held stable.
  - When `rsp_ready[grant_id]`=1, go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- A requester may drop `req_valid` before it is granted; it is simply not selected. `req_payload[i]` must be stable while `req_valid[i]`=1.
- The engine is never aborted. After a timeout, the next START relaunches the adaptor, which rewrites its registers.
- Reset values:
  - FSM = IDLE.
  - `last_grant` = NUM_REQ-1, so requester 0 has first priority.
  - `grant_id` = 0, `engine_payload` = 0, `rsp_code` = 0, `rsp_timeout` = 0, counter = 0.
  - All of `req_ready`, `rsp_valid`, `engine_start`, `busy` = 0.
- Reset asserted mid-job (any state) returns everything to the reset values immediately. No `engine_start` or `rsp_valid` is emitted.

## Timing
- Request seen in IDLE at cycle 0: `req_ready` at cycle 0, `engine_start` at cycle 1, first `engine_done` sample at cycle 2.
- `engine_done` first high in WAIT at cycle k: `rsp_valid` rises at cycle k+1.
- Timeout: `rsp_valid` rises at cycle 2+`TIMEOUT_CYCLES` (counting the `req_ready` cycle as 0).
- Response handshake at cycle r: IDLE at r+1; next `req_ready` can occur at r+1. The minimum job period is 4 cycles plus engine latency.
- `busy`=1 from cycle 1 (START) through the handshake cycle r.
- `req_ready`, `engine_start` and `rsp_valid` are never high in the same cycle.

## Test plan
- **Single job:** req_valid[2]=1 with payload 0xA5..A5; engine_done rises 10 cycles after start with rc 0x0000_0007.
  -> req_ready[2] at cycle 0, engine_start at cycle 1, engine_payload=0xA5..A5.
  -> rsp_valid[2] with rsp_code=7, rsp_timeout=0; busy drops after rsp_ready.
- **Round-robin order:** req_valid=4'b1011 held continuously, each requester re-requesting after its response.
  -> grant order 0,1,3,0,1,3; requester 2 is never granted.
- **Stale done:** engine_done held high from the previous job through START and dropped 1 cycle after start.
  -> no response from the stale level; a new done pulse 5 cycles later completes the job with its rc.
- **Timeout:** TIMEOUT_CYCLES=16, engine_done never asserted.
  -> rsp_valid at cycle 18, rsp_timeout=1, rsp_code=0.
  -> the next job starts normally and completes with rsp_timeout=0.
- **Response backpressure:** rsp_ready[1]=0 for 20 cycles, rsp_ready[0]=1 throughout, req_valid[3]=1 pending.
  -> rsp_valid[1] and rsp_code held stable for all 20 cycles; no req_ready[3] until the handshake completes.
- **Reset mid-WAIT:** resetn low for 2 cycles during WAIT.
  -> all outputs at reset values and FSM in IDLE.
  -> after release, requester 0 wins over requesters 1..3 all requesting.

Source files
------------

// File: rtl/job_dispatch_arbiter_if.sv
// Requester / response / engine-adaptor signal bundle for job_dispatch_arbiter.
// The slave modport is the arbiter side; the master modport is the environment
// (requesters plus the adaptor front end).
interface job_dispatch_arbiter_if #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned PAYLOAD_WIDTH = 1024,
  parameter int unsigned RC_WIDTH      = 32
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*PAYLOAD_WIDTH-1:0] req_payload;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [NUM_REQ-1:0]               rsp_ready;
  logic [RC_WIDTH-1:0]              rsp_code;
  logic                             rsp_timeout;
  logic                             busy;
  logic [2:0]                       grant_id;
  logic                             engine_start;
  logic [PAYLOAD_WIDTH-1:0]         engine_payload;
  logic                             engine_done;
  logic [RC_WIDTH-1:0]              engine_return_code;

  modport slave (
    input  req_valid, req_payload, rsp_ready, engine_done, engine_return_code,
    output req_ready, rsp_valid, rsp_code, rsp_timeout, busy, grant_id,
           engine_start, engine_payload
  );

  modport master (
    output req_valid, req_payload, rsp_ready, engine_done, engine_return_code,
    input  req_ready, rsp_valid, rsp_code, rsp_timeout, busy, grant_id,
           engine_start, engine_payload
  );
endinterface

// File: rtl/job_dispatch_arbiter.sv
// Round-robin sharing of one HLS job adaptor between NUM_REQ requesters.
// Each granted job: latch payload, pulse engine_start, wait for done or timeout,
// then hold a one-hot response until the granted requester accepts it.
module job_dispatch_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned PAYLOAD_WIDTH  = 1024,
  parameter int unsigned RC_WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1048575,
  parameter int unsigned TO_WIDTH       = 20
) (
  input logic                   clk,
  input logic                   resetn,
  job_dispatch_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdxW-1:0] LastInit = IdxW'(NUM_REQ - 1);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] ToLast = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

  state_e                   state_q;
  logic [IdxW-1:0]          last_grant_q;
  logic [IdxW-1:0]          grant_pos_q;
  logic [PAYLOAD_WIDTH-1:0] payload_q;
  logic [RC_WIDTH-1:0]      rsp_code_q;
  logic                     rsp_timeout_q;
  logic                     engine_start_q;
  logic                     busy_q;
  logic [NUM_REQ-1:0]       rsp_valid_q;
  logic [TO_WIDTH-1:0]      to_cnt_q;

  logic                     sel_found;
  logic [IdxW-1:0]          sel_pos;
  logic [3:0]               cand;
  logic [NUM_REQ-1:0]       ready_oh;
  logic [NUM_REQ-1:0]       grant_oh;
  logic                     rsp_accept;
  logic [PAYLOAD_WIDTH-1:0] slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice[g] = bus.req_payload[g*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
  end

  // Round-robin pick: first valid requester scanning upward from last_grant+1.
  always_comb begin
    sel_found = 1'b0;
    sel_pos   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 4'(last_grant_q) + 4'd1 + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!sel_found && bus.req_valid[cand[IdxW-1:0]]) begin
        sel_found = 1'b1;
        sel_pos   = cand[IdxW-1:0];
      end
    end
  end

  // Acceptance pulse in the IDLE grant cycle; forced low while reset is held.
  always_comb begin
    ready_oh = '0;
    if (resetn && state_q == StIdle && sel_found) ready_oh[sel_pos] = 1'b1;
  end

  // One-hot of the granted requester, used to raise its response.
  always_comb begin
    grant_oh = '0;
    grant_oh[grant_pos_q] = 1'b1;
  end

  // rsp_valid_q is one-hot at the grant, so this only sees the granted rsp_ready.
  assign rsp_accept = (bus.rsp_ready & rsp_valid_q) != '0;

  // Job FSM with registered outputs; engine_done is not looked at in START
  // because it may still be high from the previous job.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      last_grant_q   <= LastInit;
      grant_pos_q    <= '0;
      payload_q      <= '0;
      rsp_code_q     <= '0;
      rsp_timeout_q  <= 1'b0;
      engine_start_q <= 1'b0;
      busy_q         <= 1'b0;
      rsp_valid_q    <= '0;
      to_cnt_q       <= '0;
    end else begin
      engine_start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (sel_found) begin
            payload_q      <= slice[sel_pos];
            grant_pos_q    <= sel_pos;
            last_grant_q   <= sel_pos;
            engine_start_q <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= StStart;
          end
        end
        StStart: begin
          to_cnt_q <= '0;
          state_q  <= StWait;
        end
        StWait: begin
          if (bus.engine_done) begin
            rsp_code_q    <= bus.engine_return_code;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= grant_oh;
            state_q       <= StResp;
          end else if (TimeoutEn && to_cnt_q == ToLast) begin
            rsp_code_q    <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= grant_oh;
            state_q       <= StResp;
          end else begin
            to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
          end
        end
        StResp: begin
          if (rsp_accept) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready      = ready_oh;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_code       = rsp_code_q;
  assign bus.rsp_timeout    = rsp_timeout_q;
  assign bus.busy           = busy_q;
  assign bus.grant_id       = 3'(grant_pos_q);
  assign bus.engine_start   = engine_start_q;
  assign bus.engine_payload = payload_q;

endmodule

// File: tb/tb_job_dispatch_arbiter.sv
// Directed bench for job_dispatch_arbiter: inputs change 1ns after posedge,
// outputs are sampled on the negedge of the same cycle.
module tb_job_dispatch_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned PW = 64;
  localparam int unsigned RW = 32;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  job_dispatch_arbiter_if #(.NUM_REQ(NR), .PAYLOAD_WIDTH(PW), .RC_WIDTH(RW)) bus ();

  job_dispatch_arbiter #(
    .NUM_REQ(NR), .PAYLOAD_WIDTH(PW), .RC_WIDTH(RW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(20)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [PW-1:0] pl [NR];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_payloads();
    for (int i = 0; i < NR; i++) bus.req_payload[i*PW +: PW] = pl[i];
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) pl[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    load_payloads();
    bus.req_valid = '1; bus.rsp_ready = '0; bus.engine_done = 1'b0; bus.engine_return_code = '0;
    #1 resetn = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
    n_cmp++; if (bus.engine_start !== 1'b0) begin n_bad++; $display("FAIL reset_engine_start: got %b want 0", bus.engine_start); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.grant_id !== 3'd0) begin n_bad++; $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
    n_cmp++; if (bus.engine_payload !== 64'h0) begin n_bad++; $display("FAIL reset_payload: got %h want 0", bus.engine_payload); end
    n_cmp++; if (bus.rsp_code !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_code: got %h want 0", bus.rsp_code); end
    n_cmp++; if (bus.rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_timeout: got %b want 0", bus.rsp_timeout); end
    bus.req_valid = '0;
    cyc(1);
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL reset_idle_no_req: got %b want 0000", bus.req_ready); end
  endtask

  task automatic test_single_job();
    cyc(1);
    pl[2] = {8{8'hA5}};
    load_payloads();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_req_ready: got %b want 0100", bus.req_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_c0: got %b want 0", bus.busy); end
    cyc(1);
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++; if (bus.engine_start !== 1'b1) begin n_bad++; $display("FAIL single_start: got %b want 1", bus.engine_start); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_c1: got %b want 1", bus.busy); end
    n_cmp++; if (bus.engine_payload !== {8{8'hA5}}) begin n_bad++; $display("FAIL single_payload: got %h want a5..a5", bus.engine_payload); end
    n_cmp++; if (bus.grant_id !== 3'd2) begin n_bad++; $display("FAIL single_grant_id: got %0d want 2", bus.grant_id); end
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL single_ready_c1: got %b want 0000", bus.req_ready); end
    cyc(9);
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL single_early_rsp: got %b want 0000", bus.rsp_valid); end
    n_cmp++; if (bus.engine_start !== 1'b0) begin n_bad++; $display("FAIL single_start_once: got %b want 0", bus.engine_start); end
    cyc(1);
    bus.engine_done = 1'b1; bus.engine_return_code = 32'h0000_0007;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL single_rsp_c11: got %b want 0000", bus.rsp_valid); end
    cyc(1);
    bus.engine_done = 1'b0; bus.engine_return_code = '0; bus.rsp_ready = 4'b0100;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 0100", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_code !== 32'd7) begin n_bad++; $display("FAIL single_rsp_code: got %h want 7", bus.rsp_code); end
    n_cmp++; if (bus.rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL single_rsp_timeout: got %b want 0", bus.rsp_timeout); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_hs: got %b want 1", bus.busy); end
    cyc(1);
    bus.rsp_ready = '0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b want 0", bus.busy); end
    n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL single_rsp_drop: got %b want 0000", bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    int unsigned order [6];
    logic [3:0] exp_oh;
    bit got;
    order = '{0, 1, 3, 0, 1, 3};
    cyc(1);
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
    bus.req_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      exp_oh = 4'b0001 << order[i];
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk);
        if (bus.req_ready !== 4'b0) got = 1'b1;
        else cyc(1);
      end
      n_cmp++; if (bus.req_ready !== exp_oh) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", i, bus.req_ready, exp_oh); end
      cyc(1);
      @(negedge clk);
      n_cmp++; if (bus.grant_id !== 3'(order[i])) begin n_bad++; $display("FAIL rr_grant_id_%0d: got %0d want %0d", i, bus.grant_id, order[i]); end
      cyc(1);
      bus.engine_done = 1'b1; bus.engine_return_code = 32'h100 + 32'(i);
      cyc(1);
      bus.engine_done = 1'b0; bus.rsp_ready = '1;
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== exp_oh) begin n_bad++; $display("FAIL rr_rsp_valid_%0d: got %b want %b", i, bus.rsp_valid, exp_oh); end
      n_cmp++; if (bus.rsp_code !== 32'h100 + 32'(i)) begin n_bad++; $display("FAIL rr_rsp_code_%0d: got %h want %h", i, bus.rsp_code, 32'h100 + 32'(i)); end
      cyc(1);
      bus.rsp_ready = '0;
    end
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL rr_idle: got %b want 0000", bus.req_ready); end
  endtask

  task automatic test_stale_done();
    cyc(1);
    bus.engine_done = 1'b1; bus.engine_return_code = 32'hDEAD; bus.req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL stale_req_ready: got %b want 0001", bus.req_ready); end
    cyc(1);
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++; if (bus.engine_start !== 1'b1) begin n_bad++; $display("FAIL stale_start: got %b want 1", bus.engine_start); end
    cyc(1);
    bus.engine_done = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL stale_no_rsp_c%0d: got %b want 0000", c, bus.rsp_valid); end
      cyc(1);
    end
    bus.engine_done = 1'b1; bus.engine_return_code = 32'h55;
    cyc(1);
    bus.engine_done = 1'b0; bus.rsp_ready = 4'b0001;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL stale_rsp_valid: got %b want 0001", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_code !== 32'h55) begin n_bad++; $display("FAIL stale_rsp_code: got %h want 55", bus.rsp_code); end
    cyc(1);
    bus.rsp_ready = '0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL stale_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_timeout();
    cyc(1);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL to_req_ready: got %b want 0010", bus.req_ready); end
    cyc(1);
    bus.req_valid = '0;
    cyc(16);
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL to_early_c17: got %b want 0000", bus.rsp_valid); end
    cyc(1);
    bus.rsp_ready = 4'b0010;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL to_rsp_valid_c18: got %b want 0010", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_timeout !== 1'b1) begin n_bad++; $display("FAIL to_rsp_timeout: got %b want 1", bus.rsp_timeout); end
    n_cmp++; if (bus.rsp_code !== 32'h0) begin n_bad++; $display("FAIL to_rsp_code: got %h want 0", bus.rsp_code); end
    cyc(1);
    bus.rsp_ready = '0; bus.req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL to_next_ready: got %b want 0100", bus.req_ready); end
    cyc(1);
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++; if (bus.engine_payload !== {8{8'hA5}}) begin n_bad++; $display("FAIL to_next_payload: got %h want a5..a5", bus.engine_payload); end
    cyc(1);
    bus.engine_done = 1'b1; bus.engine_return_code = 32'h99;
    cyc(1);
    bus.engine_done = 1'b0; bus.rsp_ready = 4'b0100;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL to_next_rsp_valid: got %b want 0100", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL to_next_timeout: got %b want 0", bus.rsp_timeout); end
    n_cmp++; if (bus.rsp_code !== 32'h99) begin n_bad++; $display("FAIL to_next_code: got %h want 99", bus.rsp_code); end
    cyc(1);
    bus.rsp_ready = '0;
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    cyc(1);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_req_ready: got %b want 0010", bus.req_ready); end
    cyc(1);
    bus.req_valid = 4'b1000;
    cyc(1);
    bus.engine_done = 1'b1; bus.engine_return_code = 32'hABCD;
    cyc(1);
    bus.engine_done = 1'b0; bus.engine_return_code = '0; bus.rsp_ready = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL bp_rsp_valid_%0d: got %b want 0010", c, bus.rsp_valid); end
      n_cmp++; if (bus.rsp_code !== 32'hABCD) begin n_bad++; $display("FAIL bp_rsp_code_%0d: got %h want abcd", c, bus.rsp_code); end
      n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL bp_no_ready_%0d: got %b want 0000", c, bus.req_ready); end
      cyc(1);
    end
    bus.rsp_ready = 4'b0011;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL bp_ready_hs: got %b want 0000", bus.req_ready); end
    cyc(1);
    bus.rsp_ready = '0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_ready_after: got %b want 1000", bus.req_ready); end
    cyc(1);
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++; if (bus.engine_payload !== pl[3]) begin n_bad++; $display("FAIL bp_payload3: got %h want %h", bus.engine_payload, pl[3]); end
  endtask

  task automatic test_reset_mid_wait();
    cyc(2);
    resetn = 1'b0; bus.req_valid = 4'b1111;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0000", bus.rsp_valid); end
    n_cmp++; if (bus.engine_start !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %b want 0", bus.engine_start); end
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.grant_id !== 3'd0) begin n_bad++; $display("FAIL rst_grant_id: got %0d want 0", bus.grant_id); end
    n_cmp++; if (bus.engine_payload !== 64'h0) begin n_bad++; $display("FAIL rst_payload: got %h want 0", bus.engine_payload); end
    n_cmp++; if (bus.rsp_code !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_code: got %h want 0", bus.rsp_code); end
    cyc(1);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy_2: got %b want 0", bus.busy); end
    cyc(1);
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_first_grant: got %b want 0001", bus.req_ready); end
    cyc(1);
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++; if (bus.engine_start !== 1'b1) begin n_bad++; $display("FAIL rst_restart: got %b want 1", bus.engine_start); end
    n_cmp++; if (bus.engine_payload !== pl[0]) begin n_bad++; $display("FAIL rst_payload0: got %h want %h", bus.engine_payload, pl[0]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_stale_done();
    test_timeout();
    test_back_pressure();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
